// File: rtl/frame_update_scheduler.sv
// Runs the per-frame update engines one at a time during vertical blanking.
// Includes a per-task timeout, a frame divider and sticky overrun/timeout flags.
module frame_update_scheduler #(
  parameter int unsigned NUM_TASKS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned FRAME_DIV      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 v_sync,
  input  logic                 enable,
  input  logic [NUM_TASKS-1:0] task_done,
  input  logic                 err_clr,
  output logic [NUM_TASKS-1:0] task_start,
  output logic                 busy,
  output logic                 frame_tick,
  output logic [15:0]          frame_count,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int unsigned IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_TASKS-1:0] start_q, start_d;
  logic                 vs_q;
  logic                 busy_q, busy_d;
  logic                 tick_q, tick_d;
  logic                 ovr_q, ovr_d;
  logic                 terr_q, terr_d;
  logic                 entry_c, exit_c, busy_c, advance_c;

  assign entry_c = vs_q & ~v_sync;
  assign exit_c  = ~vs_q & v_sync;
  assign busy_c  = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      div_q   <= '0;
      count_q <= '0;
      start_q <= '0;
      vs_q    <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      div_q   <= div_d;
      count_q <= count_d;
      start_q <= start_d;
      vs_q    <= v_sync;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    div_d     = div_q;
    count_d   = count_q;
    ovr_d     = ovr_q;
    terr_d    = terr_q;
    advance_c = 1'b0;

    // Clear first so that a set in the same cycle takes priority.
    if (err_clr) begin
      ovr_d  = 1'b0;
      terr_d = 1'b0;
    end
    if (busy_c && (entry_c || exit_c)) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (entry_c && enable) begin
          if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            idx_d   = '0;
            state_d = S_START;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (task_done[idx_q]) begin
          advance_c = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          terr_d    = 1'b1;
          advance_c = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
        if (advance_c) begin
          if (idx_q == IDX_W'(NUM_TASKS - 1)) begin
            state_d = S_DONE;
            count_d = count_q + 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they align with it.
    start_d = (state_d == S_START) ? (NUM_TASKS'(1) << idx_d) : '0;
    busy_d  = (state_d != S_IDLE);
    tick_d  = (state_d == S_DONE);
  end

  assign task_start  = start_q;
  assign busy        = busy_q;
  assign frame_tick  = tick_q;
  assign frame_count = count_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;

endmodule
